// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one memory request at a time, hands words to decode.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module ifu_fetch #(
    parameter int                    PC_WIDTH   = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = 64'h8000_0000,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic                  halt,
    output logic                  fetch_fault,
    output logic [PC_WIDTH-1:0]   fault_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]           perf_fetch_cnt,
    output logic [63:0]           perf_stall_cnt,
    output logic [31:0]           perf_kill_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_reqAddr;
    logic [PC_WIDTH-1:0]   r_instPc;
    logic [PC_WIDTH-1:0]   r_faultPc;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_kill;
    logic                  r_reqValid;
    logic                  r_instValid;
    logic                  r_fault;

    logic                  w_redirMis;
    logic                  w_reqFire;
    logic                  w_instFire;
    logic                  w_drop;
    logic                  w_faultNow;
    logic [PC_WIDTH-1:0]   w_faultPc;
    logic [PC_WIDTH-1:0]   w_redirOrPc;
    logic [PC_WIDTH-1:0]   w_holdNextPc;

    assign w_redirMis   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_reqFire    = r_reqValid && imem_req_ready;
    assign w_instFire   = r_instValid && inst_ready;
    assign w_redirOrPc  = redirect_valid ? redirect_pc : r_pc;
    assign w_holdNextPc = redirect_valid ? redirect_pc : (r_pc + PC_WIDTH'(4));
    // An aligned redirect arriving with the response makes that response wrong-path as well.
    assign w_drop       = (r_state == S_WAIT) && imem_rsp_valid && (r_kill || redirect_valid);

    always_comb begin
        w_faultNow = 1'b0;
        w_faultPc  = r_pc;
        if (w_redirMis) begin
            w_faultPc = redirect_pc;
            w_faultNow = (r_state == S_REQ) || (r_state == S_WAIT) ||
                         ((r_state == S_HOLD) && !(w_instFire && halt));
        end else if ((r_state == S_WAIT) && imem_rsp_valid && imem_rsp_err && !w_drop) begin
            w_faultNow = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_reqValid  <= 1'b0;
            r_reqAddr   <= RESET_PC;
            r_instValid <= 1'b0;
            r_inst      <= NOP_INST;
            r_instPc    <= '0;
            r_fault     <= 1'b0;
            r_faultPc   <= '0;
        end else if (w_faultNow) begin
            r_fault     <= 1'b1;
            r_faultPc   <= w_faultPc;
            r_reqValid  <= 1'b0;
            r_instValid <= 1'b0;
            r_inst      <= NOP_INST;
            r_state     <= S_HALT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_reqValid <= 1'b1;
                    r_reqAddr  <= r_pc;
                    r_state    <= S_REQ;
                end
                S_REQ: begin
                    // The pending address cannot be withdrawn, so its eventual response is killed.
                    if (redirect_valid) begin
                        r_pc   <= redirect_pc;
                        r_kill <= 1'b1;
                    end
                    if (w_reqFire) begin
                        r_reqValid <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_drop) begin
                        r_kill     <= 1'b0;
                        r_pc       <= w_redirOrPc;
                        r_reqAddr  <= w_redirOrPc;
                        r_reqValid <= 1'b1;
                        r_state    <= S_REQ;
                    end else if (imem_rsp_valid) begin
                        r_inst      <= imem_rsp_data;
                        r_instPc    <= r_pc;
                        r_instValid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (redirect_valid) begin
                        r_pc   <= redirect_pc;
                        r_kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_instFire && halt) begin
                        r_instValid <= 1'b0;
                        r_inst      <= NOP_INST;
                        r_state     <= S_HALT;
                    end else if (w_instFire || redirect_valid) begin
                        r_pc        <= w_holdNextPc;
                        r_reqAddr   <= w_holdNextPc;
                        r_reqValid  <= 1'b1;
                        r_instValid <= 1'b0;
                        r_inst      <= NOP_INST;
                        r_state     <= S_REQ;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign imem_req_valid = r_reqValid;
    assign imem_req_addr  = r_reqAddr;
    assign inst_valid     = r_instValid;
    assign inst           = r_inst;
    assign inst_pc        = r_instPc;
    assign fetch_fault    = r_fault;
    assign fault_pc       = r_faultPc;

`ifdef IFU_PERF_CNT_EN
    logic [63:0] r_perfFetch;
    logic [63:0] r_perfStall;
    logic [31:0] r_perfKill;
    logic        w_stall;

    assign w_stall = ((r_state == S_REQ)  && !imem_req_ready) ||
                     ((r_state == S_WAIT) && !imem_rsp_valid) ||
                     ((r_state == S_HOLD) && !inst_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perfFetch <= '0;
            r_perfStall <= '0;
            r_perfKill  <= '0;
        end else begin
            if (w_instFire) r_perfFetch <= r_perfFetch + 64'd1;
            if (w_stall)    r_perfStall <= r_perfStall + 64'd1;
            if (w_drop && !w_redirMis) r_perfKill <= r_perfKill + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perfFetch;
    assign perf_stall_cnt = r_perfStall;
    assign perf_kill_cnt  = r_perfKill;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: table of fetch transactions plus hand-written redirect/halt/fault sequences,
// with request addresses and decoded instructions checked through scoreboard queues.
module tb_ifu_fetch;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [63:0] ERR_ADDR = 64'h8000_0008;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        logic        redir;
        logic [63:0] redirPc;
        int          readyStall;
        int          holdStall;
        logic        halt;
        logic        pushReq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        fetch_fault;
    logic [63:0] fault_pc;

    int          checks = 0;
    int          errors = 0;
    int          rspDelay = 0;
    logic [63:0] reqQ[$];
    logic [95:0] instQ[$];
    vec_t        vecs[7];

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0050_0093;
        if (a == 64'h8000_0204) return 32'h0010_0073;
        return a[31:0] ^ 32'h1234_5013;
    endfunction

    function automatic vec_t mkVec(input logic [63:0] a, input logic r, input logic [63:0] rpc,
                                   input int rs, input int hs, input logic h, input logic pr);
        vec_t v;
        v.addr = a; v.inst = memWord(a); v.redir = r; v.redirPc = rpc;
        v.readyStall = rs; v.holdStall = hs; v.halt = h; v.pushReq = pr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rstReqValid", imem_req_valid, 0);
        checkOutput("rstInstValid", inst_valid, 0);
        checkOutput("rstInst", inst, NOP);
        checkOutput("rstInstPc", inst_pc, 0);
        checkOutput("rstFault", fetch_fault, 0);
        checkOutput("rstFaultPc", fault_pc, 0);
    endtask

    // Starts just after a rising edge; returns on the following falling edge with reset released.
    task automatic resetDut();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkResetState();
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.pushReq) reqQ.push_back(v.addr);
        instQ.push_back({v.inst, v.addr});
        imem_req_ready = (v.readyStall == 0);
        if (v.readyStall > 0) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (imem_req_valid) break;
            end
            checkOutput("reqValidSeen", imem_req_valid, 1);
            for (int i = 0; i < v.readyStall; i++) begin
                checkOutput("reqAddrHeld", imem_req_addr, v.addr);
                @(negedge clk);
            end
            @(posedge clk); #1;
            imem_req_ready = 1'b1;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (inst_valid) break;
            checkOutput("nopWhileInvalid", inst, NOP);
        end
        checkOutput("instValidSeen", inst_valid, 1);
        for (int i = 0; i < v.holdStall; i++) begin
            checkOutput("instHeld", inst, v.inst);
            checkOutput("instPcHeld", inst_pc, v.addr);
            @(negedge clk);
        end
        @(posedge clk); #1;
        inst_ready = 1'b1; redirect_valid = v.redir; redirect_pc = v.redirPc; halt = v.halt;
        @(posedge clk); #1;
        inst_ready = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    endtask

    // Memory model: answers each accepted request rspDelay cycles after the request enters WAIT.
    initial begin
        logic [63:0] a;
        int d;
        imem_rsp_valid = 1'b0; imem_rsp_data = NOP; imem_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                a = imem_req_addr;
                @(posedge clk); #1;
                d = rspDelay;
                repeat (d) begin @(posedge clk); #1; end
                imem_rsp_valid = 1'b1; imem_rsp_data = memWord(a); imem_rsp_err = (a == ERR_ADDR);
                @(posedge clk); #1;
                imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
            end
        end
    end

    // Scoreboard: every request and decode handshake must match the next queued expectation.
    initial begin
        logic [63:0] e;
        logic [95:0] ei;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                if (reqQ.size() == 0) checkOutput("reqUnexpected", imem_req_addr, 64'hDEAD);
                else begin e = reqQ.pop_front(); checkOutput("reqAddr", imem_req_addr, e); end
            end
            if (rst_n && inst_valid && inst_ready) begin
                if (instQ.size() == 0) checkOutput("instUnexpected", inst_pc, 64'hDEAD);
                else begin
                    ei = instQ.pop_front();
                    checkOutput("instWord", inst, ei[95:64]);
                    checkOutput("instPc", inst_pc, ei[63:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = mkVec(64'h8000_0000, 0, 64'h0, 0, 0, 0, 1);
        vecs[1] = mkVec(64'h8000_0004, 1, 64'h8000_0100, 0, 0, 0, 1);
        vecs[2] = mkVec(64'h8000_0100, 0, 64'h0, 5, 4, 0, 1);
        vecs[3] = mkVec(64'h8000_0104, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1);
        vecs[4] = mkVec(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 0, 0, 1);
        vecs[5] = mkVec(64'h0000_0000_0000_0000, 1, 64'h8000_0010, 0, 0, 0, 1);
        vecs[6] = mkVec(64'h8000_0010, 0, 64'h0, 0, 1, 0, 1);

        imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; halt = 1'b0;
        @(posedge clk); #1;
        resetDut();
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Redirect while waiting on a slow response: that response must be discarded.
        reqQ.push_back(64'h8000_0014);
        reqQ.push_back(64'h8000_0200);
        rspDelay = 3;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("killNoInst", inst_valid, 0);
            if (imem_req_valid) break;
        end
        checkOutput("reqAfterKill", imem_req_valid, 1);
        rspDelay = 0;
        applyStimulus(mkVec(64'h8000_0200, 0, 64'h0, 0, 0, 0, 0));
        applyStimulus(mkVec(64'h8000_0204, 1, 64'h8000_0300, 0, 0, 1, 1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("haltNoReq", imem_req_valid, 0);
            checkOutput("haltNoInst", inst_valid, 0);
        end

        @(posedge clk); #1;
        resetDut();
        applyStimulus(mkVec(64'h8000_0000, 0, 64'h0, 0, 0, 0, 1));
        applyStimulus(mkVec(64'h8000_0004, 0, 64'h0, 0, 0, 0, 1));
        reqQ.push_back(ERR_ADDR);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetch_fault) break;
        end
        checkOutput("errFault", fetch_fault, 1);
        checkOutput("errFaultPc", fault_pc, ERR_ADDR);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("errNoReq", imem_req_valid, 0);
            checkOutput("errSticky", fetch_fault, 1);
        end
        @(posedge clk); #1;
        resetDut();

        applyStimulus(mkVec(64'h8000_0000, 1, 64'h8000_0102, 0, 0, 0, 1));
        @(negedge clk);
        checkOutput("misFault", fetch_fault, 1);
        checkOutput("misFaultPc", fault_pc, 64'h8000_0102);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("misNoReq", imem_req_valid, 0);
            checkOutput("misSticky", fetch_fault, 1);
        end
        @(posedge clk); #1;
        resetDut();

        checkOutput("reqQEmpty", 64'(reqQ.size()), 0);
        checkOutput("instQEmpty", 64'(instQ.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit that produces the 32-bit `inst` word consumed by the decode/control stage.
- Owns the PC and issues one request at a time to instruction memory through a valid/ready request channel and a valid-only response channel.
- Presents each fetched instruction and its PC to decode through a valid/ready handshake.
- Accepts jump/branch redirects and a halt (ebreak) request from downstream.

Parameters:
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- PC_WIDTH, 64, PC and address width (equals `CPU_WIDTH`).
- INST_WIDTH, 32, instruction width.
- NOP_INST, 32'h0000_0013, value driven on `inst` whenever `inst_valid`=0 (addi x0,x0,0, so decode never sees an unknown code).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_WIDTH  fetch address
- imem_rsp_valid  in  1  response data valid (one per accepted request)
- imem_rsp_data  in  INST_WIDTH  fetched word
- imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid
- inst_valid  out  1  `inst`/`inst_pc` valid toward decode
- inst_ready  in  1  decode consumes instruction
- inst  out  INST_WIDTH  instruction to decode
- inst_pc  out  PC_WIDTH  PC of `inst`
- redirect_valid  in  1  jump/branch taken
- redirect_pc  in  PC_WIDTH  target PC
- halt  in  1  ebreak seen on current instruction
- fetch_fault  out  1  sticky fault flag
- fault_pc  out  PC_WIDTH  PC that faulted

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, pc=RESET_PC, kill=0.
  - imem_req_valid=0, inst_valid=0, inst=NOP_INST, inst_pc=0, fetch_fault=0, fault_pc=0.
  - Reset mid-transaction abandons the transaction. A response that arrives after reset while state≠WAIT is ignored.
- IDLE: move to REQ on the next cycle.
- REQ:
  - Drive imem_req_valid=1 and imem_req_addr=pc.
  - The address is held stable until imem_req_ready.
  - On handshake, go to WAIT.
- WAIT: on imem_rsp_valid:
  - kill=1: drop the response, clear kill, go to REQ.
  - imem_rsp_err=1: fetch_fault=1, fault_pc=pc, go to HALT.
  - Otherwise: register inst=imem_rsp_data and inst_pc=pc, set inst_valid=1 on the next cycle, go to HOLD.
- HOLD:
  - inst and inst_pc are held stable until inst_ready.
  - On inst_ready: pc = redirect_valid ? redirect_pc : pc+4; inst_valid=0 (inst=NOP_INST); go to REQ.
  - If halt=1 on the handshake cycle instead, go to HALT. halt has priority over redirect.
- Redirect while in REQ or WAIT (no decoded instruction outstanding):
  - pc=redirect_pc.
  - If a request has been accepted or is accepted in the same cycle, set kill=1.
  - The address is never changed while imem_req_valid=1 and not yet accepted; the new pc is used from the next REQ entry.
  - When several redirects arrive before the response, the last one wins.
- Redirect in HOLD without inst_ready: discard the held instruction, inst_valid=0, pc=redirect_pc, go to REQ.
- Misaligned redirect (redirect_pc[1:0]≠0) in any state that accepts it: fetch_fault=1, fault_pc=redirect_pc, go to HALT.
- HALT: no requests, inst_valid=0. Sticky until reset.
- PC arithmetic is modulo 2^PC_WIDTH; pc+4 from all-ones-minus-3 wraps to 0.
- One outstanding request maximum. Best-case throughput is one instruction per 3 cycles (REQ, WAIT with same-cycle response, HOLD with ready).

Optional Feature:
- IFU_PERF_CNT_EN defined:
  - Adds outputs perf_fetch_cnt[63:0], perf_stall_cnt[63:0], perf_kill_cnt[31:0], all reset to 0.
  - perf_fetch_cnt increments on each inst_valid&inst_ready handshake.
  - perf_stall_cnt increments on each cycle in REQ without ready, in WAIT without response, or in HOLD without ready.
  - perf_kill_cnt increments on each dropped response.
  - All counters wrap.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then memory always ready with a 1-cycle response of 32'h00500093 -> first request addr=0x8000_0000 two cycles after reset release; inst_valid=1 with inst=0x00500093 and inst_pc=0x8000_0000; next request addr=0x8000_0004.
- Redirect to 0x8000_0100 asserted with inst_ready in HOLD -> next imem_req_addr=0x8000_0100, inst_pc of that fetch=0x8000_0100.
- Redirect to 0x8000_0200 in WAIT with response delayed 3 cycles -> response dropped (inst_valid stays 0), next request addr=0x8000_0200.
- imem_req_ready held low 5 cycles -> imem_req_addr stable for all 5 cycles; inst_ready held low 4 cycles in HOLD -> inst/inst_pc stable and inst=NOP_INST whenever invalid.
- halt=1 on handshake of inst 0x00100073 -> no further requests for 20 cycles; rst_n=0 for one cycle -> restart at 0x8000_0000.
- imem_rsp_err=1 at pc 0x8000_0008, and separately redirect_pc=0x8000_0102 -> fetch_fault=1 with fault_pc=0x8000_0008 / 0x8000_0102 respectively; HALT entered; the flag clears only on reset.
